// File: rtl/i2c_pkg.sv
// Shared types and constants for the N-byte I2C master.
package i2c_pkg;

  localparam int BITS_PER_BYTE = 8;

  // Transfer sequencing states.
  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    STOP
  } state_t;

  // Quarter of an SCL bit slot: SCL low in Q0, high in Q1-Q2, low in Q3.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  // Quarter held while idle. START occupies Q2-Q3 so that the first address
  // bit naturally begins on the Q3 -> Q0 wrap.
  localparam quarter_t Q_IDLE = Q2;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: counts DIV clocks per quarter and steps the quarter
// index. Held at Q_IDLE with a cleared counter while run is low.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic     CLK,
  input  logic     RESET,
  input  logic     run,
  output quarter_t q,
  output logic     tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  quarter_t      q_q, q_d;

  // tick marks the last clock of the current quarter.
  assign tick = run && (cnt_q == CW'(DIV - 1));
  assign q    = q_q;

  // Next-count and next-quarter selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    q_d   = q_q;
    if (!run) begin
      cnt_d = '0;
      q_d   = Q_IDLE;
    end else if (tick) begin
      cnt_d = '0;
      q_d   = quarter_t'(q_q + 2'd1);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and quarter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (RESET) begin
      cnt_q <= '0;
      q_q   <= Q_IDLE;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/i2c_master_nbyte.sv
// I2C master performing one addressed read or write of 0..NBYTES bytes.
// Optional build macro I2C_NACK_ABORT_EN: a NACK on an address or write ACK
// slot ends the transfer with STOP right after that slot.
module i2c_master_nbyte
  import i2c_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int DIV    = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START_STB,
  input  logic                          RNW,
  input  logic [6:0]                    I2C_ADDR,
  input  logic [$clog2(NBYTES+1)-1:0]   BYTE_CNT,
  input  logic [BITS_PER_BYTE*NBYTES-1:0] WR_DATA,
  input  logic                          SDA_IN,
  output logic                          SDA_OUT,
  output logic                          SDA_OE,
  output logic                          SCL,
  output logic [BITS_PER_BYTE*NBYTES-1:0] RD_DATA,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          NACK
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int DW = BITS_PER_BYTE * NBYTES;

`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT_ON_NACK = 1'b1;
`else
  localparam bit ABORT_ON_NACK = 1'b0;
`endif

  state_t          state_q, state_d;
  logic            rnw_q, rnw_d;
  logic [CW-1:0]   n_q, n_d, byte_q, byte_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [DW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            scl_q, scl_d, sda_out_q, sda_out_d, sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d, done_q, done_d, nack_q, nack_d;

  quarter_t        q, q_n;
  logic            tick, slot_end, sample, last_byte;

  i2c_quarter_timer #(.DIV(DIV)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .run   (state_q != IDLE),
    .q     (q),
    .tick  (tick)
  );

  assign slot_end  = tick && (q == Q3);
  assign sample    = tick && (q == Q1);
  assign last_byte = (byte_q + CW'(1)) == n_q;
  // Quarter the timer will present next cycle; bus outputs are decoded from it.
  assign q_n = (state_q == IDLE) ? Q_IDLE : (tick ? quarter_t'(q + 2'd1) : q);

  // Sequencing, data path and registered bus-output decode.
  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    n_d     = n_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    nack_d  = nack_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: if (START_STB) begin
        state_d = START;
        rnw_d   = RNW;
        n_d     = (BYTE_CNT > CW'(NBYTES)) ? CW'(NBYTES) : BYTE_CNT;
        wr_d    = WR_DATA;
        sh_d    = {I2C_ADDR, RNW};
        nack_d  = 1'b0;
        rd_d    = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
      START: if (tick && (q == Q3)) state_d = ADDR;
      ADDR, WRITE: if (slot_end) begin
        sh_d  = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(BITS_PER_BYTE - 1))
          state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
      end
      ADDR_ACK: begin
        if (sample && SDA_IN) nack_d = 1'b1;
        if (slot_end) begin
          if ((n_q == '0) || (ABORT_ON_NACK && nack_q)) begin
            state_d = STOP;
          end else if (rnw_q) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
            sh_d    = wr_q[DW-1 -: BITS_PER_BYTE];
            wr_d    = wr_q << BITS_PER_BYTE;
          end
        end
      end
      WRITE_ACK: begin
        if (sample && SDA_IN) nack_d = 1'b1;
        if (slot_end) begin
          if (last_byte || (ABORT_ON_NACK && nack_q)) begin
            state_d = STOP;
          end else begin
            state_d = WRITE;
            byte_d  = byte_q + CW'(1);
            sh_d    = wr_q[DW-1 -: BITS_PER_BYTE];
            wr_d    = wr_q << BITS_PER_BYTE;
          end
        end
      end
      READ: begin
        if (sample) sh_d = {sh_q[6:0], SDA_IN};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d = READ_ACK;
            for (int i = 0; i < NBYTES; i++)
              if (byte_q == CW'(i)) rd_d[DW-1-BITS_PER_BYTE*i -: BITS_PER_BYTE] = sh_q;
          end
        end
      end
      READ_ACK: if (slot_end) begin
        if (last_byte) begin
          state_d = STOP;
        end else begin
          state_d = READ;
          byte_d  = byte_q + CW'(1);
        end
      end
      STOP: if (tick && (q == Q2)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    scl_d     = (q_n == Q1) || (q_n == Q2);
    sda_out_d = 1'b1;
    sda_oe_d  = 1'b0;
    case (state_d)
      IDLE:  scl_d = 1'b1;
      START: begin
        scl_d     = 1'b1;
        sda_oe_d  = 1'b1;
        sda_out_d = (q_n == Q_IDLE);
      end
      ADDR, WRITE: begin
        sda_oe_d  = 1'b1;
        sda_out_d = sh_d[7];
      end
      READ_ACK: begin
        sda_oe_d  = 1'b1;
        sda_out_d = last_byte;
      end
      STOP: begin
        sda_oe_d  = (q_n != Q2);
        sda_out_d = (q_n == Q2);
      end
      default: ;
    endcase
  end

  // All FSM state and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      rnw_q     <= 1'b0;
      n_q       <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      scl_q     <= 1'b1;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      n_q       <= n_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      scl_q     <= scl_d;
      sda_out_q <= sda_out_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
    end
  end

  assign SCL     = scl_q;
  assign SDA_OUT = sda_out_q;
  assign SDA_OE  = sda_oe_q;
  assign RD_DATA = rd_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign NACK    = nack_q;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Bench for i2c_master_nbyte (NBYTES=2, DIV=2) with a behavioural I2C target
// on an open-drain bus and a frame scoreboard. Honours I2C_NACK_ABORT_EN.
module tb_i2c_master_nbyte;

`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START_STB, RNW, SDA_IN;
  logic [6:0]  I2C_ADDR;
  logic [1:0]  BYTE_CNT;
  logic [15:0] WR_DATA, RD_DATA;
  logic        SDA_OUT, SDA_OE, SCL, BUSY, DONE, NACK;

  int total = 0, bad = 0, cyc = 0;

  logic [8:0] exp_q[$];
  logic       tgt_sda = 1'b1;
  logic       tgt_ack [0:2];
  logic [7:0] tgt_rd  [0:1];

  // Monitor / target state.
  logic       scl_p = 1'b1, sda_p = 1'b1;
  bit         in_xfer = 1'b0, rd_mode = 1'b0, rd_stop = 1'b0;
  int         rises = 0, fcount = 0;
  logic [8:0] frame = '0;

  i2c_master_nbyte #(.NBYTES(2), .DIV(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START_STB (START_STB),
    .RNW       (RNW),
    .I2C_ADDR  (I2C_ADDR),
    .BYTE_CNT  (BYTE_CNT),
    .WR_DATA   (WR_DATA),
    .SDA_IN    (SDA_IN),
    .SDA_OUT   (SDA_OUT),
    .SDA_OE    (SDA_OE),
    .SCL       (SCL),
    .RD_DATA   (RD_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .NACK      (NACK)
  );

  // Wired-AND open-drain bus.
  assign SDA_IN = (SDA_OE ? SDA_OUT : 1'b1) & tgt_sda;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic ack);
    exp_q.push_back({b, ack});
  endtask

  // Bus monitor and target: frames compared against the scoreboard on the
  // ninth SCL rise; target drives SDA after each SCL fall.
  always @(negedge CLK) begin
    int f, pos;
    if (SCL && scl_p && sda_p && !SDA_IN) begin
      in_xfer = 1'b1; rises = 0; rd_mode = 1'b0; rd_stop = 1'b0;
    end else if (SCL && scl_p && !sda_p && SDA_IN) begin
      in_xfer = 1'b0;
    end else if (in_xfer && SCL && !scl_p) begin
      frame = {frame[7:0], SDA_IN};
      if (rises == 7) rd_mode = SDA_IN;
      if ((rises % 9) == 8) begin
        check($sformatf("frame%0d_queued", fcount), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check($sformatf("frame%0d", fcount), 32'(frame), 32'(exp_q.pop_front()));
        fcount++;
        if (rd_mode && rises > 8 && SDA_IN) rd_stop = 1'b1;
      end
      rises++;
    end else if (in_xfer && !SCL && scl_p) begin
      f = rises / 9; pos = rises % 9;
      tgt_sda = 1'b1;
      if (pos == 8) begin
        if (f == 0) tgt_sda = tgt_ack[0];
        else if (!rd_mode && f <= 2) tgt_sda = tgt_ack[f];
      end else if (rd_mode && !rd_stop && f >= 1 && f <= 2) begin
        tgt_sda = tgt_rd[f-1][7-pos];
      end
    end
    scl_p = SCL;
    sda_p = SDA_IN;
  end

  task automatic wait_done(input string tag, output int t);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    t = cyc;
  endtask

  task automatic xfer(input string tag, input logic rnw, input logic [6:0] addr,
                      input logic [1:0] cnt, input logic [15:0] wr, input int exp_len);
    int c0, c1;
    @(negedge CLK);
    RNW = rnw; I2C_ADDR = addr; BYTE_CNT = cnt; WR_DATA = wr; START_STB = 1'b1;
    @(negedge CLK);
    START_STB = 1'b0;
    check({tag, "_busy"}, 32'(BUSY), 32'd1);
    c0 = cyc;
    wait_done(tag, c1);
    check({tag, "_len"}, 32'(c1 - c0), 32'(exp_len));
    check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
    repeat (4) @(negedge CLK);
    check({tag, "_frames_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c0, c1;
    RESET = 1'b1; START_STB = 1'b0; RNW = 1'b0; I2C_ADDR = '0; BYTE_CNT = '0; WR_DATA = '0;
    tgt_ack = '{1'b0, 1'b0, 1'b0};
    tgt_rd  = '{8'h5A, 8'hC3};
    repeat (3) @(negedge CLK);
    check("rst_scl", 32'(SCL), 32'd1);
    check("rst_sda_out", 32'(SDA_OUT), 32'd1);
    check("rst_sda_oe", 32'(SDA_OE), 32'd0);
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_nack", 32'(NACK), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Two-byte write, all ACKed.
    push(8'h34, 1'b0); push(8'hAA, 1'b0); push(8'hAE, 1'b0);
    xfer("wr2", 1'b0, 7'h1A, 2'd2, 16'hAAAE, 226);
    check("wr2_nack", 32'(NACK), 32'd0);

    // Two-byte read: master ACKs byte 0, NACKs byte 1.
    push(8'h35, 1'b0); push(8'h5A, 1'b0); push(8'hC3, 1'b1);
    xfer("rd2", 1'b1, 7'h1A, 2'd2, 16'h0000, 226);
    check("rd2_data", 32'(RD_DATA), 32'h5AC3);
    check("rd2_nack", 32'(NACK), 32'd0);

    // Address probe; RD_DATA cleared at start.
    push(8'h34, 1'b0);
    xfer("probe", 1'b0, 7'h1A, 2'd0, 16'hFFFF, 82);
    check("probe_rd_data", 32'(RD_DATA), 32'd0);

    // Address NACK.
    tgt_ack[0] = 1'b1;
    push(8'h34, 1'b1);
    if (!ABORT) begin push(8'hAA, 1'b0); push(8'hAE, 1'b0); end
    xfer("anack", 1'b0, 7'h1A, 2'd2, 16'hAAAE, ABORT ? 82 : 226);
    check("anack_nack", 32'(NACK), 32'd1);
    tgt_ack[0] = 1'b0;

    // NACK on first write byte; BYTE_CNT=3 clamps to 2.
    tgt_ack[1] = 1'b1;
    push(8'h34, 1'b0); push(8'hAA, 1'b1);
    if (!ABORT) push(8'hAE, 1'b0);
    xfer("dnack", 1'b0, 7'h1A, 2'd3, 16'hAAAE, ABORT ? 154 : 226);
    check("dnack_nack", 32'(NACK), 32'd1);
    tgt_ack[1] = 1'b0;

    // Reset in the middle of the first write byte.
    push(8'h34, 1'b0);
    @(negedge CLK);
    RNW = 1'b0; I2C_ADDR = 7'h1A; BYTE_CNT = 2'd2; WR_DATA = 16'hAAAE; START_STB = 1'b1;
    @(negedge CLK);
    START_STB = 1'b0;
    repeat (100) @(negedge CLK);
    check("mid_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_scl", 32'(SCL), 32'd1);
    check("mid_rst_sda_oe", 32'(SDA_OE), 32'd0);
    check("mid_rst_sda_out", 32'(SDA_OUT), 32'd1);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    in_xfer = 1'b0;
    tgt_sda = 1'b1;
    check("mid_rst_frames_left", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    push(8'h34, 1'b0); push(8'h55, 1'b0);
    xfer("post_rst", 1'b0, 7'h1A, 2'd1, 16'h5500, 154);
    check("post_rst_nack", 32'(NACK), 32'd0);

    // START_STB held through a transfer and its DONE cycle.
    push(8'h44, 1'b0); push(8'h46, 1'b0);
    @(negedge CLK);
    RNW = 1'b0; I2C_ADDR = 7'h22; BYTE_CNT = 2'd0; START_STB = 1'b1;
    @(negedge CLK);
    check("hold_busy1", 32'(BUSY), 32'd1);
    c0 = cyc;
    I2C_ADDR = 7'h23;
    wait_done("hold1", c1);
    check("hold1_len", 32'(c1 - c0), 32'd82);
    check("hold1_busy_at_done", 32'(BUSY), 32'd0);
    @(negedge CLK);
    check("hold_busy2", 32'(BUSY), 32'd1);
    c0 = cyc;
    START_STB = 1'b0;
    wait_done("hold2", c1);
    check("hold2_len", 32'(c1 - c0), 32'd82);
    repeat (4) @(negedge CLK);
    check("hold_frames_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
